// File: rtl/fcsr_rm_unit_if.sv
// Signal bundle between the FP pipeline/CSR unit and fcsr_rm_unit.
// The pipeline side drives the master modport; the fcsr block implements the slave.
interface fcsr_rm_unit_if;
  logic        id_fp_valid;
  logic [2:0]  id_rm;
  logic        id_ex_en;
  logic        id_ex_flush;
  logic [2:0]  ex_rm;
  logic        ex_rm_valid;
  logic        id_rm_illegal;
  logic        wb_fflags_valid;
  logic [4:0]  wb_fflags;
  logic        csr_valid;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic        csr_hit;
  logic [31:0] csr_rdata;
  logic [2:0]  frm_o;
  logic [4:0]  fflags_o;

  modport master (
    output id_fp_valid, id_rm, id_ex_en, id_ex_flush,
    output wb_fflags_valid, wb_fflags,
    output csr_valid, csr_addr, csr_op, csr_wdata,
    input  ex_rm, ex_rm_valid, id_rm_illegal, csr_hit, csr_rdata, frm_o, fflags_o
  );

  modport slave (
    input  id_fp_valid, id_rm, id_ex_en, id_ex_flush,
    input  wb_fflags_valid, wb_fflags,
    input  csr_valid, csr_addr, csr_op, csr_wdata,
    output ex_rm, ex_rm_valid, id_rm_illegal, csr_hit, csr_rdata, frm_o, fflags_o
  );
endinterface

// File: rtl/fcsr_rm_unit.sv
// RV32F fcsr (frm + fflags) with rounding-mode resolution into ID/EX,
// flag accrual from writeback and Zicsr access to fflags/frm/fcsr.
module fcsr_rm_unit #(
  parameter logic [2:0] FRM_RESET    = 3'b000,
  parameter logic [4:0] FFLAGS_RESET = 5'b00000
) (
  input logic           clk,
  input logic           reset,
  fcsr_rm_unit_if.slave bus
);
  localparam logic [11:0] ADDR_FFLAGS = 12'h001;
  localparam logic [11:0] ADDR_FRM    = 12'h002;
  localparam logic [11:0] ADDR_FCSR   = 12'h003;

  logic [2:0]  frm_q, frm_d;
  logic [4:0]  fflags_q, fflags_d;
  logic [2:0]  ex_rm_q, ex_rm_d;
  logic        ex_rm_valid_q, ex_rm_valid_d;
  logic [4:0]  fflags_acc;
  logic        csr_hit;
  logic        csr_we;
  logic [31:0] csr_old;
  logic [7:0]  csr_new;
  logic [2:0]  eff_rm;
  logic        rm_illegal;
  logic        unused_wdata;

  // Retiring FP op is older than the CSR op, so its flags land first.
  always_comb begin
    if (bus.wb_fflags_valid) begin
      fflags_acc = fflags_q | bus.wb_fflags;
    end else begin
      fflags_acc = fflags_q;
    end
  end

  // Address decode and pre-update read value.
  always_comb begin
    csr_hit = 1'b0;
    csr_old = 32'h0000_0000;
    case (bus.csr_addr)
      ADDR_FFLAGS: begin csr_hit = 1'b1; csr_old = {27'h0, fflags_acc}; end
      ADDR_FRM:    begin csr_hit = 1'b1; csr_old = {29'h0, frm_q}; end
      ADDR_FCSR:   begin csr_hit = 1'b1; csr_old = {24'h0, frm_q, fflags_acc}; end
      default:     begin csr_hit = 1'b0; csr_old = 32'h0000_0000; end
    endcase
  end

  // Zicsr read-modify-write on the low byte; upper wdata bits never matter.
  always_comb begin
    case (bus.csr_op)
      2'b01:   csr_new = bus.csr_wdata[7:0];
      2'b10:   csr_new = csr_old[7:0] | bus.csr_wdata[7:0];
      2'b11:   csr_new = csr_old[7:0] & ~bus.csr_wdata[7:0];
      default: csr_new = csr_old[7:0];
    endcase
  end

  assign csr_we       = bus.csr_valid & csr_hit & (bus.csr_op != 2'b00);
  assign unused_wdata = ^bus.csr_wdata[31:8];

  // Next fcsr state.
  always_comb begin
    frm_d    = frm_q;
    fflags_d = fflags_acc;
    if (csr_we) begin
      case (bus.csr_addr)
        ADDR_FFLAGS: fflags_d = csr_new[4:0];
        ADDR_FRM:    frm_d    = csr_new[2:0];
        ADDR_FCSR:   begin frm_d = csr_new[7:5]; fflags_d = csr_new[4:0]; end
        default:     begin frm_d = frm_q; fflags_d = fflags_acc; end
      endcase
    end else begin
      frm_d    = frm_q;
      fflags_d = fflags_acc;
    end
  end

  // Dynamic rm sees a same-cycle frm write via frm_d.
  always_comb begin
    if (bus.id_rm == 3'b111) begin
      eff_rm = frm_d;
    end else begin
      eff_rm = bus.id_rm;
    end
    rm_illegal = bus.id_fp_valid &
                 ((eff_rm == 3'b101) | (eff_rm == 3'b110) | (eff_rm == 3'b111));
  end

  // ID/EX boundary: flush beats advance, otherwise hold.
  always_comb begin
    if (bus.id_ex_flush) begin
      ex_rm_d       = 3'b000;
      ex_rm_valid_d = 1'b0;
    end else if (bus.id_ex_en) begin
      ex_rm_d       = eff_rm;
      ex_rm_valid_d = bus.id_fp_valid & ~rm_illegal;
    end else begin
      ex_rm_d       = ex_rm_q;
      ex_rm_valid_d = ex_rm_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      frm_q         <= FRM_RESET;
      fflags_q      <= FFLAGS_RESET;
      ex_rm_q       <= 3'b000;
      ex_rm_valid_q <= 1'b0;
    end else begin
      frm_q         <= frm_d;
      fflags_q      <= fflags_d;
      ex_rm_q       <= ex_rm_d;
      ex_rm_valid_q <= ex_rm_valid_d;
    end
  end

  assign bus.ex_rm         = ex_rm_q;
  assign bus.ex_rm_valid   = ex_rm_valid_q;
  assign bus.id_rm_illegal = rm_illegal;
  assign bus.csr_hit       = csr_hit;
  assign bus.csr_rdata     = csr_old;
  assign bus.frm_o         = frm_q;
  assign bus.fflags_o      = fflags_q;
endmodule

// File: tb/tb_fcsr_rm_unit.sv
// Directed self-checking bench for fcsr_rm_unit with a scoreboard of registered state.
module tb_fcsr_rm_unit;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  fcsr_rm_unit_if bus ();

  fcsr_rm_unit #(.FRM_RESET(3'b000), .FFLAGS_RESET(5'b00000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] frm;
    logic [4:0] fflags;
    logic [2:0] ex_rm;
    logic       ex_valid;
  } exp_t;

  exp_t        sb_q[$];
  logic [2:0]  m_frm;
  logic [4:0]  m_fflags;
  logic [2:0]  m_ex_rm;
  logic        m_ex_valid;
  logic [31:0] last_rdata;
  logic        last_ill;
  logic        last_hit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock of stimulus, entered and left at a falling edge.
  task automatic step(input logic rst, input logic fpv, input logic [2:0] rm,
                      input logic en, input logic flush,
                      input logic wbv, input logic [4:0] wbf,
                      input logic cv, input logic [11:0] addr,
                      input logic [1:0] op, input logic [31:0] wd);
    logic [4:0]  acc;
    logic        hit;
    logic [31:0] old;
    logic [31:0] v;
    logic [2:0]  nfrm;
    logic [4:0]  nff;
    logic [2:0]  erm;
    logic        ill;
    exp_t        e;
    reset               = rst;
    bus.id_fp_valid     = fpv;
    bus.id_rm           = rm;
    bus.id_ex_en        = en;
    bus.id_ex_flush     = flush;
    bus.wb_fflags_valid = wbv;
    bus.wb_fflags       = wbf;
    bus.csr_valid       = cv;
    bus.csr_addr        = addr;
    bus.csr_op          = op;
    bus.csr_wdata       = wd;

    acc = wbv ? (m_fflags | wbf) : m_fflags;
    hit = (addr == 12'h001) || (addr == 12'h002) || (addr == 12'h003);
    old = 32'h0;
    if (addr == 12'h001) old = {27'h0, acc};
    else if (addr == 12'h002) old = {29'h0, m_frm};
    else if (addr == 12'h003) old = {24'h0, m_frm, acc};
    nfrm = m_frm;
    nff  = acc;
    if (cv && hit && (op != 2'b00)) begin
      if (op == 2'b01) v = wd;
      else if (op == 2'b10) v = old | wd;
      else v = old & ~wd;
      if (addr == 12'h001) nff = v[4:0];
      else if (addr == 12'h002) nfrm = v[2:0];
      else begin nfrm = v[7:5]; nff = v[4:0]; end
    end
    erm = (rm == 3'd7) ? nfrm : rm;
    ill = fpv && (erm >= 3'd5);

    #1;
    last_rdata = bus.csr_rdata;
    last_ill   = bus.id_rm_illegal;
    last_hit   = bus.csr_hit;
    check("csr_hit", {31'h0, last_hit}, {31'h0, hit});
    check("csr_rdata", last_rdata, old);
    check("id_rm_illegal", {31'h0, last_ill}, {31'h0, ill});

    if (rst) begin
      m_frm = 3'd0; m_fflags = 5'd0; m_ex_rm = 3'd0; m_ex_valid = 1'b0;
    end else begin
      m_frm    = nfrm;
      m_fflags = nff;
      if (flush) begin
        m_ex_rm = 3'd0; m_ex_valid = 1'b0;
      end else if (en) begin
        m_ex_rm = erm; m_ex_valid = fpv && !ill;
      end
    end
    e.frm = m_frm; e.fflags = m_fflags; e.ex_rm = m_ex_rm; e.ex_valid = m_ex_valid;
    sb_q.push_back(e);

    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check("frm_o", {29'h0, bus.frm_o}, {29'h0, e.frm});
    check("fflags_o", {27'h0, bus.fflags_o}, {27'h0, e.fflags});
    check("ex_rm", {29'h0, bus.ex_rm}, {29'h0, e.ex_rm});
    check("ex_rm_valid", {31'h0, bus.ex_rm_valid}, {31'h0, e.ex_valid});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_frm = 3'd0; m_fflags = 5'd0; m_ex_rm = 3'd0; m_ex_valid = 1'b0;
    reset = 1'b1;
    bus.id_fp_valid = 1'b0; bus.id_rm = 3'd0; bus.id_ex_en = 1'b0; bus.id_ex_flush = 1'b0;
    bus.wb_fflags_valid = 1'b0; bus.wb_fflags = 5'd0;
    bus.csr_valid = 1'b0; bus.csr_addr = 12'h0; bus.csr_op = 2'b00; bus.csr_wdata = 32'h0;
    @(negedge clk);

    // reset wins over a write, accrual and a valid decode
    step(1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 5'h1f, 1'b1, 12'h003, 2'b01, 32'hff);
    check("reset_ex_valid", {31'h0, bus.ex_rm_valid}, 32'h0);
    check("reset_frm", {29'h0, bus.frm_o}, 32'h0);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'h0, 1'b0, 12'h000, 2'b00, 32'h0);

    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'h0, 1'b1, 12'h003, 2'b00, 32'h0);
    check("rd_fcsr_after_reset", last_rdata, 32'h0);
    check("frm_after_reset", {29'h0, bus.frm_o}, 32'h0);

    // dynamic rm resolves to frm
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'h0, 1'b1, 12'h002, 2'b01, 32'h3);
    step(1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 5'h0, 1'b0, 12'h000, 2'b00, 32'h0);
    check("dyn_rm_3", {28'h0, bus.ex_rm_valid, bus.ex_rm}, 32'hb);
    step(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 5'h0, 1'b0, 12'h000, 2'b00, 32'h0);
    check("static_rm_1", {28'h0, bus.ex_rm_valid, bus.ex_rm}, 32'h9);

    // illegal rounding modes
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'h0, 1'b1, 12'h002, 2'b01, 32'h5);
    step(1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 5'h0, 1'b0, 12'h000, 2'b00, 32'h0);
    check("dyn_frm5_illegal", {31'h0, last_ill}, 32'h1);
    check("dyn_frm5_ex_valid", {31'h0, bus.ex_rm_valid}, 32'h0);
    step(1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 5'h0, 1'b0, 12'h000, 2'b00, 32'h0);
    check("rm6_illegal", {31'h0, last_ill}, 32'h1);
    step(1'b0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 5'h0, 1'b0, 12'h000, 2'b00, 32'h0);
    check("no_fp_not_illegal", {31'h0, last_ill}, 32'h0);

    // flag accrual and same-cycle CSR access
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 5'h01, 1'b0, 12'h000, 2'b00, 32'h0);
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 5'h04, 1'b0, 12'h000, 2'b00, 32'h0);
    check("accrue_101", {27'h0, bus.fflags_o}, 32'h5);
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 5'h02, 1'b1, 12'h001, 2'b10, 32'h8);
    check("rs_with_accrual_rdata", last_rdata, 32'h7);
    check("rs_with_accrual_flags", {27'h0, bus.fflags_o}, 32'hf);
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 5'h10, 1'b1, 12'h001, 2'b11, 32'h1);
    check("rc_with_accrual_rdata", last_rdata, 32'h1f);
    check("rc_with_accrual_flags", {27'h0, bus.fflags_o}, 32'h1e);
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 5'h00, 1'b0, 12'h000, 2'b00, 32'h0);

    // stall holds ex_rm, flush beats enable
    step(1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 5'h0, 1'b0, 12'h000, 2'b00, 32'h0);
    step(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 5'h0, 1'b0, 12'h000, 2'b00, 32'h0);
    step(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 5'h0, 1'b0, 12'h000, 2'b00, 32'h0);
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'h0, 1'b0, 12'h000, 2'b00, 32'h0);
    check("stall_hold", {28'h0, bus.ex_rm_valid, bus.ex_rm}, 32'ha);
    step(1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 5'h0, 1'b0, 12'h000, 2'b00, 32'h0);
    check("flush_beats_en", {28'h0, bus.ex_rm_valid, bus.ex_rm}, 32'h0);

    // fcsr write bypassed into a same-cycle dynamic decode
    step(1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 5'h0, 1'b1, 12'h003, 2'b01, 32'h1e0);
    check("bypass_illegal", {31'h0, last_ill}, 32'h1);
    check("fcsr_write_frm", {29'h0, bus.frm_o}, 32'h7);
    check("fcsr_write_flags", {27'h0, bus.fflags_o}, 32'h0);
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'h0, 1'b1, 12'h300, 2'b01, 32'hffff_ffff);
    check("miss_hit", {31'h0, last_hit}, 32'h0);
    check("miss_rdata", last_rdata, 32'h0);
    check("miss_no_write", {24'h0, bus.frm_o, bus.fflags_o}, 32'he0);
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'h0, 1'b1, 12'h003, 2'b11, 32'h20);
    check("rc_fcsr_frm", {29'h0, bus.frm_o}, 32'h6);
    step(1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 5'h0, 1'b1, 12'h002, 2'b01, 32'hfffffff2);
    check("bypass_legal", {28'h0, bus.ex_rm_valid, bus.ex_rm}, 32'ha);

    // reset during a stall clears everything
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 5'h15, 1'b0, 12'h000, 2'b00, 32'h0);
    step(1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 5'h03, 1'b0, 12'h000, 2'b00, 32'h0);
    check("reset_mid_stall", {20'h0, bus.frm_o, bus.fflags_o, bus.ex_rm, bus.ex_rm_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
